// File: rtl/clause_break_accumulator.sv
// clause_break_accumulator: flags unsat clauses per beat and accumulates a saturating per-frame break count.
module clause_break_accumulator #(
  parameter int CLUSTER_SIZE = 20,
  parameter int NSAT = 3,
  parameter int CNT_W = 8
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  input  logic [NSAT*CLUSTER_SIZE-1:0]  var_val_i,
  input  logic [NSAT*CLUSTER_SIZE-1:0]  var_neg_i,
  input  logic [CLUSTER_SIZE-1:0]       lane_mask_i,
  input  logic                          last_i,
  output logic [CLUSTER_SIZE-1:0]       break_vec_o,
  output logic                          vec_valid_o,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [CNT_W-1:0]              break_cnt_o,
  output logic                          cnt_sat_o,
  output logic                          all_sat_o
);
  localparam int POP_W = $clog2(CLUSTER_SIZE + 1);
  localparam int SUM_W = (CNT_W > POP_W ? CNT_W : POP_W) + 1;
  localparam logic [SUM_W-1:0] MAX = {{(SUM_W-CNT_W){1'b0}}, {CNT_W{1'b1}}};
  logic [CLUSTER_SIZE-1:0] unsat;
  logic                    s1_valid, s1_last, sticky, stall, accept, advance, ovf, sticky_n;
  logic [CNT_W-1:0]        acc, sat_sum;
  logic [POP_W-1:0]        pop;
  logic [SUM_W-1:0]        sum;
  genvar g;
  for (g = 0; g < CLUSTER_SIZE; g++) begin : g_lane
    assign unsat[g] = lane_mask_i[g] & ~|(var_val_i[g*NSAT +: NSAT] ^ var_neg_i[g*NSAT +: NSAT]);
  end
  assign stall       = out_valid_o & ~out_ready_i;
  assign in_ready_o  = ~stall;
  assign accept      = in_valid_i & in_ready_o;
  assign advance     = s1_valid & ~stall;
  assign vec_valid_o = advance;
  always_comb begin
    pop = '0;
    for (int i = 0; i < CLUSTER_SIZE; i++) pop = pop + POP_W'(break_vec_o[i]);
    sum      = SUM_W'(acc) + SUM_W'(pop);
    ovf      = sum > MAX;
    sat_sum  = ovf ? MAX[CNT_W-1:0] : sum[CNT_W-1:0];
    sticky_n = sticky | ovf;
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      s1_valid    <= 1'b0;
      s1_last     <= 1'b0;
      break_vec_o <= '0;
    end else if (!stall) begin
      s1_valid <= accept;
      if (accept) begin
        break_vec_o <= unsat;
        s1_last     <= last_i;
      end
    end
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      acc         <= '0;
      sticky      <= 1'b0;
      out_valid_o <= 1'b0;
      break_cnt_o <= '0;
      cnt_sat_o   <= 1'b0;
      all_sat_o   <= 1'b1;
    end else begin
      if (out_valid_o && out_ready_i) out_valid_o <= 1'b0;
      if (advance && s1_last) begin
        break_cnt_o <= sat_sum;
        cnt_sat_o   <= sticky_n;
        all_sat_o   <= sat_sum == '0;
        out_valid_o <= 1'b1;
        acc         <= '0;
        sticky      <= 1'b0;
      end else if (advance) begin
        acc    <= sat_sum;
        sticky <= sticky_n;
      end
    end
  end
endmodule

// File: tb/tb_clause_break_accumulator.sv
// tb_clause_break_accumulator: randomized + directed scoreboard bench against a frame-level reference model.
module tb_clause_break_accumulator;
  localparam int CS = 4, NS = 3, CW = 4;
  logic clk = 0, reset_i = 1, in_valid_i = 0, last_i = 0, out_ready_i = 1;
  logic [NS*CS-1:0] var_val_i = '0, var_neg_i = '0;
  logic [CS-1:0] lane_mask_i = '0, break_vec_o;
  logic in_ready_o, vec_valid_o, out_valid_o, cnt_sat_o, all_sat_o;
  logic [CW-1:0] break_cnt_o;
  int errors = 0, checks = 0, fsum = 0;
  bit rnd_mode = 0, rdy_set = 1;
  logic [CS-1:0] vq[$];
  int cq[$];
  bit sq[$];

  clause_break_accumulator #(.CLUSTER_SIZE(CS), .NSAT(NS), .CNT_W(CW)) dut (
    .clk_i(clk), .reset_i(reset_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .var_val_i(var_val_i), .var_neg_i(var_neg_i), .lane_mask_i(lane_mask_i), .last_i(last_i),
    .break_vec_o(break_vec_o), .vec_valid_o(vec_valid_o), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .break_cnt_o(break_cnt_o), .cnt_sat_o(cnt_sat_o), .all_sat_o(all_sat_o));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk);
    #2;
    out_ready_i = rnd_mode ? ($urandom_range(0, 3) != 0) : rdy_set;
  end

  always @(negedge clk) if (!reset_i) begin
    if (vec_valid_o) begin
      if (vq.size() == 0) chk("vec_unexpected", 1, 0);
      else chk("break_vec", int'(break_vec_o), int'(vq.pop_front()));
    end
    if (out_valid_o && out_ready_i) begin
      if (cq.size() == 0) chk("result_unexpected", 1, 0);
      else begin
        int c;
        c = cq.pop_front();
        chk("break_cnt", int'(break_cnt_o), c);
        chk("all_sat", int'(all_sat_o), int'(c == 0));
        chk("cnt_sat", int'(cnt_sat_o), int'(sq.pop_front()));
      end
    end
  end

  // Reference: a clause is broken when no literal evaluates true; frame count is the clamped total.
  task automatic model(input logic [NS*CS-1:0] v, input logic [NS*CS-1:0] n, input logic [CS-1:0] m, input logic l);
    logic [CS-1:0] u;
    for (int i = 0; i < CS; i++) begin
      bit any_true = 0;
      for (int j = 0; j < NS; j++) if (v[i*NS+j] != n[i*NS+j]) any_true = 1;
      u[i] = m[i] && !any_true;
    end
    vq.push_back(u);
    fsum += $countones(u);
    if (l) begin
      cq.push_back(fsum > 15 ? 15 : fsum);
      sq.push_back(fsum > 15);
      fsum = 0;
    end
  endtask

  task automatic send(input logic [NS*CS-1:0] v, input logic [NS*CS-1:0] n, input logic [CS-1:0] m, input logic l);
    bit ok = 0;
    int t = 0;
    in_valid_i = 1; var_val_i = v; var_neg_i = n; lane_mask_i = m; last_i = l;
    while (!ok && t < 200) begin
      @(negedge clk);
      ok = in_ready_o;
      if (ok) model(v, n, m, l);
      @(posedge clk);
      #1;
      t++;
    end
    if (!ok) chk("accept_timeout", 0, 1);
    in_valid_i = 0; last_i = 0;
  endtask

  task automatic idle(input int k);
    repeat (k) begin @(posedge clk); #1; end
  endtask

  initial begin
    idle(3);
    reset_i = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_out_valid", int'(out_valid_o), 0);
      chk("idle_cnt", int'(break_cnt_o), 0);
      chk("idle_all_sat", int'(all_sat_o), 1);
      chk("idle_in_ready", int'(in_ready_o), 1);
    end
    idle(1);
    send('0, '0, 4'b1011, 1);
    chk("lat_vec_valid", int'(vec_valid_o), 1);
    chk("lat_vec", int'(break_vec_o), 4'b1011);
    chk("lat_no_result_yet", int'(out_valid_o), 0);
    idle(1);
    chk("lat_out_valid", int'(out_valid_o), 1);
    chk("lat_cnt", int'(break_cnt_o), 3);
    chk("lat_all_sat", int'(all_sat_o), 0);
    chk("lat_cnt_sat", int'(cnt_sat_o), 0);
    idle(2);
    send('0, '0, 4'b0011, 0);
    send('0, '0, 4'b0000, 0);
    send('0, '0, 4'b1111, 1);
    idle(3);
    repeat (4) send('0, '0, 4'b1111, 0);
    send('0, '0, 4'b1111, 1);
    send('1, '0, 4'b1111, 0);
    send(12'b000_000_000_111, '0, 4'b0011, 1);
    idle(4);
    rdy_set = 0;
    send('0, '0, 4'b0110, 1);
    idle(3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_in_ready", int'(in_ready_o), 0);
      chk("stall_out_valid", int'(out_valid_o), 1);
      chk("stall_cnt", int'(break_cnt_o), 2);
    end
    idle(1);
    fork
      begin idle(3); rdy_set = 1; end
      send('0, '0, 4'b1000, 1);
    join
    idle(4);
    send('0, '0, 4'b0011, 0);
    send('0, '0, 4'b0111, 0);
    idle(3);
    reset_i = 1;
    fsum = 0;
    idle(2);
    reset_i = 0;
    send('0, '0, 4'b0100, 1);
    idle(4);
    rnd_mode = 1;
    for (int i = 0; i < 300; i++) begin
      logic [NS*CS-1:0] v, n;
      logic [CS-1:0] m;
      v = NS*CS'($urandom) & NS*CS'($urandom);
      n = NS*CS'($urandom) & NS*CS'($urandom);
      m = CS'($urandom);
      send(v, n, m, $urandom_range(0, 3) == 0);
      if ($urandom_range(0, 4) == 0) idle(1);
    end
    send('0, '0, 4'b0001, 1);
    rnd_mode = 0;
    rdy_set = 1;
    idle(20);
    chk("vec_queue_drained", vq.size(), 0);
    chk("result_queue_drained", cq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
